// File: rtl/interp_seq_if.sv
// interp_seq_if: control, BRAM and engine-stream signals of the
// interpolation sequencer. The master modport is the sequencer itself; the
// slave modport is its environment (mode-select FSM, BRAMs, engine).
interface interp_seq_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  // control from the mode-select FSM
  logic              start;
  logic [1:0]        mode;
  logic [3:0]        poly_num;
  logic [ADDR_W:0]   len;
  // input BRAM port B
  logic              in_en;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_dout;
  // sample stream to the engine
  logic [1:0]        eng_mode;
  logic [3:0]        eng_order;
  logic              eng_valid;
  logic              eng_ready;
  logic [DATA_W-1:0] eng_data;
  logic              eng_last;
  // result stream from the engine
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_last;
  // output BRAM port A
  logic              out_we;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_din;
  // status
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   res_count;

  modport master (
    input  start, mode, poly_num, len, in_dout, eng_ready,
           res_valid, res_data, res_last,
    output in_en, in_addr, eng_mode, eng_order, eng_valid, eng_data, eng_last,
           res_ready, out_we, out_addr, out_din, busy, done, err, res_count
  );

  modport slave (
    output start, mode, poly_num, len, in_dout, eng_ready,
           res_valid, res_data, res_last,
    input  in_en, in_addr, eng_mode, eng_order, eng_valid, eng_data, eng_last,
           res_ready, out_we, out_addr, out_din, busy, done, err, res_count
  );
endinterface

// File: rtl/interp_sequencer.sv
// interp_sequencer: busy-phase sequencer of the interpolation datapath.
// Reads len samples from the input BRAM, streams them to the selected
// engine, writes every engine result to the output BRAM and reports
// done/err to the mode-select FSM.
// Optional build macro INTERP_SEQ_TIMEOUT_EN adds a stall watchdog that
// aborts the run after TIMEOUT_CYCLES cycles without progress.
module interp_sequencer #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic          clk,
  input logic          reset,
  interp_seq_if.master bus
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DRAIN, DONE} state_t;

  localparam logic [ADDR_W:0] ONE       = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] LEN_ZERO  = (ADDR_W + 1)'(0);
  localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, state_next;
  logic [ADDR_W:0]   rd_idx, len_r, res_count_r;
  logic [1:0]        mode_r;
  logic [3:0]        order_r;
  logic [DATA_W-1:0] data_r, out_din_r;
  logic [ADDR_W-1:0] out_addr_r;
  logic              out_we_r, err_r, last_seen_r;

  logic busy_s, start_accept, start_run, eng_hs, res_acc, overflow, res_write;
  logic last_sample, last_pending, timeout_s;

  assign busy_s       = (state == READ) || (state == WAIT) || (state == SEND) || (state == DRAIN);
  assign start_accept = bus.start && ((state == IDLE) || (state == DONE));
  assign start_run    = start_accept && (bus.mode != 2'b11) && (bus.len != LEN_ZERO);
  assign eng_hs       = (state == SEND) && bus.eng_ready;
  assign res_acc      = busy_s && bus.res_valid;
  // A result beyond the memory depth is consumed but never written.
  assign overflow     = res_acc && (res_count_r == MAX_COUNT);
  assign res_write    = res_acc && !overflow;
  assign last_sample  = (rd_idx == (len_r - ONE));
  // The final result may overtake the final sample handshake.
  assign last_pending = last_seen_r || (res_write && bus.res_last);

`ifdef INTERP_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WD_W-1:0] wd_cnt;

  assign timeout_s = ((state == SEND) || (state == DRAIN)) && !eng_hs && !res_acc &&
                     (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: count stalled SEND/DRAIN cycles, clear on any progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (eng_hs || res_acc || !((state == SEND) || (state == DRAIN))) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
`else
  // Without the watchdog the run waits indefinitely; the parameter stays
  // in the port list so both builds share one instantiation.
  assign timeout_s = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // Next-state logic; abort conditions take priority over normal flow.
  always_comb begin
    state_next = state;
    if (overflow || timeout_s) begin
      state_next = DONE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            if ((bus.mode == 2'b11) || (bus.len == LEN_ZERO)) state_next = DONE;
            else                                               state_next = READ;
          end else begin
            state_next = state;
          end
        end
        READ:    state_next = WAIT;
        WAIT:    state_next = SEND;
        SEND: begin
          if (eng_hs) begin
            if (!last_sample)      state_next = READ;
            else if (last_pending) state_next = DONE;
            else                   state_next = DRAIN;
          end else begin
            state_next = state;
          end
        end
        DRAIN: begin
          if (res_write && bus.res_last) state_next = DONE;
          else                           state_next = state;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State, indices, latched run parameters and registered BRAM write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rd_idx      <= '0;
      len_r       <= '0;
      res_count_r <= '0;
      mode_r      <= 2'b00;
      order_r     <= 4'h0;
      data_r      <= '0;
      out_we_r    <= 1'b0;
      out_addr_r  <= '0;
      out_din_r   <= '0;
      err_r       <= 1'b0;
      last_seen_r <= 1'b0;
    end else begin
      state    <= state_next;
      out_we_r <= res_write;
      // The write index always equals the number of results written so far.
      if (res_write) begin
        out_addr_r  <= res_count_r[ADDR_W-1:0];
        out_din_r   <= bus.res_data;
        res_count_r <= res_count_r + ONE;
      end
      if (res_write && bus.res_last) last_seen_r <= 1'b1;
      if (eng_hs) rd_idx <= rd_idx + ONE;
      if (state == WAIT) data_r <= bus.in_dout;
      if (overflow || timeout_s) err_r <= 1'b1;
      if (start_accept) begin
        rd_idx      <= '0;
        res_count_r <= '0;
        last_seen_r <= 1'b0;
        err_r       <= (bus.mode == 2'b11);
        if (start_run) begin
          mode_r  <= bus.mode;
          order_r <= bus.poly_num;
          len_r   <= bus.len;
        end
      end
    end
  end

  assign bus.in_en     = (state == READ);
  assign bus.in_addr   = rd_idx[ADDR_W-1:0];
  assign bus.eng_mode  = mode_r;
  assign bus.eng_order = order_r;
  assign bus.eng_valid = (state == SEND);
  assign bus.eng_data  = data_r;
  assign bus.eng_last  = (state == SEND) && last_sample;
  assign bus.res_ready = busy_s;
  assign bus.out_we    = out_we_r;
  assign bus.out_addr  = out_addr_r;
  assign bus.out_din   = out_din_r;
  assign bus.busy      = busy_s;
  assign bus.done      = (state == DONE);
  assign bus.err       = err_r;
  assign bus.res_count = res_count_r;

endmodule

// File: tb/tb_interp_sequencer.sv
// tb_interp_sequencer: directed bench for interp_sequencer with BRAM and
// echo-engine models (each result is sample + 1).
module tb_interp_sequencer;
  logic clk = 1'b0;
  logic reset;

  interp_seq_if #(.ADDR_W(10), .DATA_W(16)) bus ();

  interp_sequencer #(.ADDR_W(10), .DATA_W(16), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [15:0] in_mem  [1024];
  logic [15:0] out_mem [1024];
  logic [15:0] sent [$];
  logic [15:0] rq [$];
  int checks = 0, errors = 0;
  int n_in_en = 0, n_we = 0, n_res = 0, total_res = 0, ready_mode = 3;
  int stab_err = 0, last_cnt = 0, last_pos = -1, we_snap = 0, cyc = 0;
  bit extra = 1'b0;
  logic prev_stall = 1'b0;
  logic [15:0] prev_data = 16'h0;

  // input BRAM read port, one-cycle latency
  always @(posedge clk) if (bus.in_en) bus.in_dout <= in_mem[bus.in_addr];

  // monitor: handshakes, BRAM writes, stability of stalled samples
  always @(posedge clk) begin
    if (!reset) begin
      if (bus.in_en) n_in_en++;
      if (bus.out_we) begin out_mem[bus.out_addr] = bus.out_din; n_we++; end
      if (prev_stall && (!bus.eng_valid || bus.eng_data !== prev_data)) stab_err++;
      prev_stall = bus.eng_valid && !bus.eng_ready;
      prev_data  = bus.eng_data;
      if (bus.eng_valid && bus.eng_ready) begin
        if (bus.eng_last) begin last_cnt++; last_pos = sent.size(); end
        sent.push_back(bus.eng_data);
        rq.push_back(bus.eng_data + 16'd1);
        if (bus.eng_last && extra) rq.push_back(16'hBEEF);
      end
      if (bus.res_valid && bus.res_ready) begin void'(rq.pop_front()); n_res++; end
    end else begin
      prev_stall = 1'b0;
    end
  end

  // engine model: ready pattern and result stream
  always @(negedge clk) begin
    case (ready_mode)
      0:       bus.eng_ready = 1'b1;
      1:       bus.eng_ready = ~bus.eng_ready;
      2:       bus.eng_ready = (sent.size() < 5);
      default: bus.eng_ready = 1'b0;
    endcase
    bus.res_valid = (rq.size() != 0);
    bus.res_data  = (rq.size() != 0) ? rq[0] : 16'h0000;
    bus.res_last  = (rq.size() != 0) && (n_res + 1 == total_res);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_run();
    n_in_en = 0; n_we = 0; n_res = 0; stab_err = 0; last_cnt = 0; last_pos = -1;
    sent.delete(); rq.delete();
    for (int i = 0; i < 1024; i++) out_mem[i] = 16'h0000;
  endtask

  task automatic run_start(input logic [1:0] m, input logic [3:0] p, input logic [10:0] l);
    @(negedge clk);
    bus.start = 1'b1; bus.mode = m; bus.poly_num = p; bus.len = l;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < max) begin @(negedge clk); cyc++; end
    check("done_within_bound", bus.done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    reset = 1'b1; bus.start = 1'b0; bus.mode = 2'b00; bus.poly_num = 4'h0; bus.len = 11'd0;
    for (int i = 0; i < 1024; i++) in_mem[i] = 16'h1000 + 16'(i * 3);
    clear_run();
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_res_count", bus.res_count, 0);
    check("rst_eng_valid", bus.eng_valid, 0);
    check("rst_out_we", bus.out_we, 0);
    check("rst_in_en", bus.in_en, 0);
    reset = 1'b0;

    // linear, len 4, engine always ready
    clear_run(); total_res = 4; ready_mode = 0;
    run_start(2'b00, 4'h0, 11'd4);
    check("t1_busy", bus.busy, 1);
    wait_done(100);
    repeat (2) @(negedge clk);
    check("t1_err", bus.err, 0);
    check("t1_res_count", bus.res_count, 4);
    check("t1_res_ready_done", bus.res_ready, 0);
    check("t1_out0", out_mem[0], 16'h1001);
    check("t1_out1", out_mem[1], 16'h1004);
    check("t1_out2", out_mem[2], 16'h1007);
    check("t1_out3", out_mem[3], 16'h100A);
    check("t1_n_we", n_we, 4);
    check("t1_n_in_en", n_in_en, 4);
    check("t1_last_cnt", last_cnt, 1);
    check("t1_last_pos", last_pos, 3);

    // poly order 3, len 8, ready toggling
    clear_run(); total_res = 8; ready_mode = 1;
    run_start(2'b01, 4'h3, 11'd8);
    check("t2_done_cleared", bus.done, 0);
    check("t2_eng_order", bus.eng_order, 3);
    check("t2_eng_mode", bus.eng_mode, 1);
    wait_done(200);
    repeat (2) @(negedge clk);
    check("t2_stable", stab_err, 0);
    check("t2_n_sent", sent.size(), 8);
    for (int k = 0; k < 8 && k < sent.size(); k++)
      check("t2_order", sent[k], 16'h1000 + 16'(3 * k));
    check("t2_out7", out_mem[7], 16'h1016);
    check("t2_res_count", bus.res_count, 8);
    check("t2_err", bus.err, 0);

    // invalid mode
    clear_run(); ready_mode = 0;
    run_start(2'b11, 4'h0, 11'd4);
    check("t3_done", bus.done, 1);
    check("t3_err", bus.err, 1);
    check("t3_busy", bus.busy, 0);
    check("t3_res_count", bus.res_count, 0);
    repeat (4) @(negedge clk);
    check("t3_no_in_en", n_in_en, 0);
    check("t3_no_out_we", n_we, 0);

    // zero length
    clear_run();
    run_start(2'b00, 4'h0, 11'd0);
    check("t4_done", bus.done, 1);
    check("t4_err", bus.err, 0);
    check("t4_res_count", bus.res_count, 0);
    repeat (4) @(negedge clk);
    check("t4_no_in_en", n_in_en, 0);
    check("t4_no_out_we", n_we, 0);

    // full length with one surplus result
    clear_run(); total_res = 1025; extra = 1'b1; ready_mode = 0;
    run_start(2'b10, 4'h0, 11'd1024);
    wait_done(4000);
    repeat (3) @(negedge clk);
    extra = 1'b0;
    check("t5_n_we", n_we, 1024);
    check("t5_err", bus.err, 1);
    check("t5_res_count", bus.res_count, 1024);
    check("t5_n_sent", sent.size(), 1024);
    check("t5_out0", out_mem[0], 16'h1001);
    check("t5_out1023", out_mem[1023], 16'h1BFE);

    // reset while sample 5 is waiting in SEND
    clear_run(); total_res = 8; ready_mode = 2;
    run_start(2'b00, 4'h0, 11'd8);
    cyc = 0;
    while (!(sent.size() == 5 && bus.eng_valid === 1'b1) && cyc < 100) begin @(negedge clk); cyc++; end
    check("t6_in_send", bus.eng_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_busy", bus.busy, 0);
    check("t6_eng_valid", bus.eng_valid, 0);
    check("t6_done", bus.done, 0);
    check("t6_out_we", bus.out_we, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0; ready_mode = 3; we_snap = n_we;
    repeat (5) @(negedge clk);
    check("t6_no_writes", n_we, we_snap);
    check("t6_idle", bus.busy, 0);

    // engine never ready
    clear_run(); total_res = 4; ready_mode = 3;
    run_start(2'b00, 4'h0, 11'd4);
    cyc = 0;
    while (bus.eng_valid !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    check("t7_in_send", bus.eng_valid, 1);
`ifdef INTERP_SEQ_TIMEOUT_EN
    repeat (15) @(negedge clk);
    check("t7_not_yet", bus.done, 0);
    @(negedge clk);
    check("t7_timeout_done", bus.done, 1);
    check("t7_timeout_err", bus.err, 1);
    check("t7_eng_valid", bus.eng_valid, 0);
`else
    repeat (40) @(negedge clk);
    check("t7_still_busy", bus.busy, 1);
    check("t7_no_done", bus.done, 0);
`endif
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
